// File: rtl/debounce_bank.sv
// Multi-channel key/switch debouncer: per-channel synchroniser, stability timer,
// registered edge pulses and optional typematic auto-repeat.
module debounce_bank #(
    parameter int N             = 4,
    parameter int CNT_W         = 20,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 24_000_000,
    parameter int REPEAT_PERIOD = 6_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    output logic [N-1:0] out,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] rpt,
    output logic [N-1:0] press
);

    localparam logic [CNT_W-1:0] M = {1'b1, {(CNT_W-1){1'b0}}};
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W    = $clog2(RPT_MAX + 1);

    logic [N-1:0]     sync_q [SYNC_STAGES];
    logic [N-1:0]     s;
    logic [N-1:0]     delta;
    logic [N-1:0]     settle;
    logic [N-1:0]     rpt_ev;
    logic [CNT_W-1:0] timer [N];

    // NOTE: every flop stage, including the array stages, is cleared by the async
    // reset so no channel can emit a pulse from stale synchroniser contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: defaults first so no path through this block leaves a bit unassigned.
    always_comb begin
        delta  = s ^ out;
        settle = '0;
        for (int i = 0; i < N; i++) settle[i] = delta[i] && (timer[i] == M);
    end

    // Any cycle with s == out restarts the count, which is what rejects bounces.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) timer[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!delta[i] || settle[i]) timer[i] <= '0;
                else                        timer[i] <= timer[i] + CNT_W'(1);
            end
        end
    end

    // NOTE: non-blocking assignments keep every output register sampling the
    // pre-edge values, so pulses line up with the cycle out changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            rise  <= '0;
            fall  <= '0;
            rpt   <= '0;
            press <= '0;
        end else begin
            out   <= out ^ settle;
            rise  <= settle & s;
            fall  <= settle & ~s;
            rpt   <= rpt_ev;
            press <= (settle & s) | rpt_ev;
        end
    end

    if (REPEAT_EN != 0) begin : g_rpt
        localparam logic [RC_W-1:0] DLY = RC_W'(REPEAT_DELAY);
        localparam logic [RC_W-1:0] PER = RC_W'(REPEAT_PERIOD);

        logic [RC_W-1:0] rc [N];
        logic [N-1:0]    armed;

        // A settling channel that is currently high is releasing: no repeat then.
        always_comb begin
            rpt_ev = '0;
            for (int i = 0; i < N; i++)
                rpt_ev[i] = out[i] && !settle[i] && (rc[i] == (armed[i] ? PER : DLY));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < N; i++) rc[i] <= '0;
                armed <= '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (settle[i] && s[i]) begin
                        rc[i]    <= RC_W'(1);
                        armed[i] <= 1'b0;
                    end else if (!out[i] || settle[i]) begin
                        rc[i]    <= '0;
                        armed[i] <= 1'b0;
                    end else if (rpt_ev[i]) begin
                        rc[i]    <= RC_W'(1);
                        armed[i] <= 1'b1;
                    end else begin
                        rc[i]    <= rc[i] + RC_W'(1);
                    end
                end
            end
        end
    end else begin : g_no_rpt
        assign rpt_ev = '0;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: M=8, two sync stages, repeat 20/5, plus a
// REPEAT_EN=0 instance sharing the same inputs.
module tb_debounce_bank;

    localparam int N = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] in    = '0;
    logic [N-1:0] out, rise, fall, rpt, press;
    logic [N-1:0] out_nr, rise_nr, fall_nr, rpt_nr, press_nr;

    int n_cmp = 0;
    int n_bad = 0;

    debounce_bank #(
        .N(N), .CNT_W(4), .SYNC_STAGES(2), .REPEAT_EN(1),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in),
        .out(out), .rise(rise), .fall(fall), .rpt(rpt), .press(press)
    );

    debounce_bank #(
        .N(N), .CNT_W(4), .SYNC_STAGES(2), .REPEAT_EN(0),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut_nr (
        .clk(clk), .rst_n(rst_n), .in(in),
        .out(out_nr), .rise(rise_nr), .fall(fall_nr), .rpt(rpt_nr), .press(press_nr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_cmp++;
        if ({out, rise, fall, rpt, press} !== '0) begin
            n_bad++;
            $display("FAIL reset: out=%b rise=%b fall=%b rpt=%b press=%b, expected all 0",
                     out, rise, fall, rpt, press);
        end
        n_cmp++;
        if ({out_nr, rise_nr, fall_nr, rpt_nr, press_nr} !== '0) begin
            n_bad++;
            $display("FAIL reset_nr: out=%b rise=%b fall=%b rpt=%b press=%b, expected all 0",
                     out_nr, rise_nr, fall_nr, rpt_nr, press_nr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_press();
        logic [N-1:0] e_out, e_edge;
        in[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            e_out  = (k >= 11) ? 4'b0001 : 4'b0000;
            e_edge = (k == 11) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if ({out, rise, fall, rpt, press} !== {e_out, e_edge, 4'b0, 4'b0, e_edge}) begin
                n_bad++;
                $display("FAIL clean_press k=%0d: out=%b rise=%b fall=%b rpt=%b press=%b, expected %b %b 0000 0000 %b",
                         k, out, rise, fall, rpt, press, e_out, e_edge, e_edge);
            end
        end
        in[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            e_out  = (k < 11) ? 4'b0001 : 4'b0000;
            e_edge = (k == 11) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if ({out, rise, fall, rpt, press} !== {e_out, 4'b0, e_edge, 4'b0, 4'b0}) begin
                n_bad++;
                $display("FAIL clean_release k=%0d: out=%b rise=%b fall=%b rpt=%b press=%b, expected %b 0000 %b 0000 0000",
                         k, out, rise, fall, rpt, press, e_out, e_edge);
            end
        end
    endtask

    task automatic test_bounce();
        logic [N-1:0] e_out, e_edge;
        in[1] = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            if (k == 7) in[1] = 1'b0;
            if (k == 8) in[1] = 1'b1;
            step();
            e_out  = (k >= 18) ? 4'b0010 : 4'b0000;
            e_edge = (k == 18) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if ({out, rise, fall, rpt, press} !== {e_out, e_edge, 4'b0, 4'b0, e_edge}) begin
                n_bad++;
                $display("FAIL bounce k=%0d: out=%b rise=%b fall=%b rpt=%b press=%b, expected %b %b 0000 0000 %b",
                         k, out, rise, fall, rpt, press, e_out, e_edge, e_edge);
            end
        end
        in[1] = 1'b0;
        repeat (12) step();
        n_cmp++;
        if (out !== 4'b0000) begin
            n_bad++;
            $display("FAIL bounce_release: out=%b, expected 0000", out);
        end
    endtask

    task automatic test_auto_repeat();
        logic [N-1:0] e_out, e_rpt, e_fall;
        int pulses = 0;
        in[2] = 1'b1;
        repeat (11) step();
        n_cmp++;
        if ({out, rise, press} !== {4'b0100, 4'b0100, 4'b0100}) begin
            n_bad++;
            $display("FAIL repeat_rise: out=%b rise=%b press=%b, expected 0100 0100 0100",
                     out, rise, press);
        end
        // Released so that the fall lands exactly where a T+60 repeat would be.
        for (int j = 1; j <= 70; j++) begin
            if (j == 50) in[2] = 1'b0;
            step();
            e_rpt  = (j >= 20 && j <= 55 && (j - 20) % 5 == 0) ? 4'b0100 : 4'b0000;
            e_fall = (j == 60) ? 4'b0100 : 4'b0000;
            e_out  = (j < 60) ? 4'b0100 : 4'b0000;
            if (rpt[2]) pulses++;
            n_cmp++;
            if ({out, rise, fall, rpt, press} !== {e_out, 4'b0, e_fall, e_rpt, e_rpt}) begin
                n_bad++;
                $display("FAIL auto_repeat j=%0d: out=%b rise=%b fall=%b rpt=%b press=%b, expected %b 0000 %b %b %b",
                         j, out, rise, fall, rpt, press, e_out, e_fall, e_rpt, e_rpt);
            end
        end
        n_cmp++;
        if (pulses != 8) begin
            n_bad++;
            $display("FAIL repeat_count: got %0d rpt pulses, expected 8", pulses);
        end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] e_out, e_rise, e_fall;
        in[3] = 1'b1;
        repeat (11) step();
        in = 4'b0001;
        for (int j = 1; j <= 12; j++) begin
            step();
            e_out  = (j >= 11) ? 4'b0001 : 4'b1000;
            e_rise = (j == 11) ? 4'b0001 : 4'b0000;
            e_fall = (j == 11) ? 4'b1000 : 4'b0000;
            n_cmp++;
            if ({out, rise, fall, rpt, press} !== {e_out, e_rise, e_fall, 4'b0, e_rise}) begin
                n_bad++;
                $display("FAIL simultaneous j=%0d: out=%b rise=%b fall=%b rpt=%b press=%b, expected %b %b %b 0000 %b",
                         j, out, rise, fall, rpt, press, e_out, e_rise, e_fall, e_rise);
            end
        end
        in = 4'b0000;
        repeat (12) step();
        n_cmp++;
        if (out !== 4'b0000) begin
            n_bad++;
            $display("FAIL simultaneous_release: out=%b, expected 0000", out);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] e_out, e_edge, e_rpt;
        in[2] = 1'b1;
        repeat (11) step();
        for (int j = 1; j <= 27; j++) begin
            if (j == 21) in[1] = 1'b1;
            step();
            e_rpt = (j == 20 || j == 25) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if ({out, rpt} !== {4'b0100, e_rpt}) begin
                n_bad++;
                $display("FAIL reset_mid_pre j=%0d: out=%b rpt=%b, expected 0100 %b", j, out, rpt, e_rpt);
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out, rise, fall, rpt, press} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_async: out=%b rise=%b fall=%b rpt=%b press=%b, expected all 0",
                     out, rise, fall, rpt, press);
        end
        in = 4'b0000;
        @(negedge clk);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            n_cmp++;
            if ({out, rise, fall, rpt, press} !== '0) begin
                n_bad++;
                $display("FAIL reset_mid_quiet k=%0d: out=%b rise=%b fall=%b rpt=%b press=%b, expected all 0",
                         k, out, rise, fall, rpt, press);
            end
        end
        in[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            e_out  = (k >= 11) ? 4'b0100 : 4'b0000;
            e_edge = (k == 11) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if ({out, rise, press} !== {e_out, e_edge, e_edge}) begin
                n_bad++;
                $display("FAIL reset_mid_relatch k=%0d: out=%b rise=%b press=%b, expected %b %b %b",
                         k, out, rise, press, e_out, e_edge, e_edge);
            end
        end
        in[2] = 1'b0;
        repeat (12) step();
    endtask

    task automatic test_no_repeat();
        logic [N-1:0] e_out, e_edge;
        in[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            e_out  = (k >= 11) ? 4'b0001 : 4'b0000;
            e_edge = (k == 11) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if ({out_nr, rise_nr, fall_nr, rpt_nr, press_nr} !== {e_out, e_edge, 4'b0, 4'b0, e_edge}) begin
                n_bad++;
                $display("FAIL no_repeat k=%0d: out=%b rise=%b fall=%b rpt=%b press=%b, expected %b %b 0000 0000 %b",
                         k, out_nr, rise_nr, fall_nr, rpt_nr, press_nr, e_out, e_edge, e_edge);
            end
        end
        in[0] = 1'b0;
        repeat (12) step();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_simultaneous();
        test_reset_mid();
        test_no_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
